// File: rtl/vga_timing_gen_if.sv
// Raster output bundle of the VGA timing generator: DAC pins, current position
// and the one-pixel-ahead fetch request for the colour stage.
interface vga_timing_gen_if;
    logic       vga_clk;
    logic       hsync_n;
    logic       vsync_n;
    logic       blank_n;
    logic       sync_n;
    logic [9:0] x;
    logic [9:0] y;
    logic       frame_start;
    logic       pixel_req;
    logic [9:0] req_x;
    logic [9:0] req_y;

    modport master (
        output vga_clk, hsync_n, vsync_n, blank_n, sync_n,
        output x, y, frame_start, pixel_req, req_x, req_y
    );

    modport slave (
        input vga_clk, hsync_n, vsync_n, blank_n, sync_n,
        input x, y, frame_start, pixel_req, req_x, req_y
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running 640x480@60 raster timing from the system clock: registered sync,
// blank and pixel-clock pins, current position and a next-pixel fetch request.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic             clock,
    input  logic             reset,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;
    localparam int DW       = $clog2(CLK_DIV);

    logic [DW-1:0] div_cnt, div_nxt;
    logic          pix_en;
    logic [9:0]    h_cnt, v_cnt;
    logic [9:0]    h_nxt, v_nxt;
    logic [9:0]    h_la, v_la;
    logic          start_q;
    logic          req_fire;

    function automatic logic is_active(input logic [9:0] h, input logic [9:0] v);
        return (h < 10'(H_ACTIVE)) && (v < 10'(V_ACTIVE));
    endfunction

    function automatic logic in_hsync(input logic [9:0] h);
        return (h >= 10'(HS_FIRST)) && (h <= 10'(HS_LAST));
    endfunction

    function automatic logic in_vsync(input logic [9:0] v);
        return (v >= 10'(VS_FIRST)) && (v <= 10'(VS_LAST));
    endfunction

    // Raster position one pixel after (h,v), wrapping at line and frame end.
    function automatic logic [19:0] advance(input logic [9:0] h, input logic [9:0] v);
        logic [9:0] hn, vn;
        hn = h + 10'd1;
        vn = v;
        if (h == 10'(H_TOTAL - 1)) begin
            hn = '0;
            vn = (v == 10'(V_TOTAL - 1)) ? 10'd0 : v + 10'd1;
        end
        return {vn, hn};
    endfunction

    always_comb begin
        pix_en  = (div_cnt == DW'(CLK_DIV - 1));
        div_nxt = pix_en ? '0 : div_cnt + DW'(1);
        h_nxt   = h_cnt;
        v_nxt   = v_cnt;
        if (pix_en) {v_nxt, h_nxt} = advance(h_cnt, v_cnt);
        {v_la, h_la} = advance(h_nxt, v_nxt);
        // Out of reset the counters sit on the last position, so the lookahead
        // is the origin and the first fetch can go out immediately.
        req_fire = (pix_en || start_q) && is_active(h_la, v_la);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt         <= '0;
            h_cnt           <= 10'(H_TOTAL - 1);
            v_cnt           <= 10'(V_TOTAL - 1);
            start_q         <= 1'b1;
            vga.vga_clk     <= 1'b0;
            vga.hsync_n     <= 1'b1;
            vga.vsync_n     <= 1'b1;
            vga.blank_n     <= 1'b0;
            vga.frame_start <= 1'b0;
            vga.pixel_req   <= 1'b0;
            vga.req_x       <= '0;
            vga.req_y       <= '0;
        end else begin
            div_cnt         <= div_nxt;
            h_cnt           <= h_nxt;
            v_cnt           <= v_nxt;
            start_q         <= 1'b0;
            // High for the second half of the pixel so the DAC samples mid-pixel.
            vga.vga_clk     <= (div_nxt >= DW'(CLK_DIV / 2));
            vga.hsync_n     <= !in_hsync(h_nxt);
            vga.vsync_n     <= !in_vsync(v_nxt);
            vga.blank_n     <= is_active(h_nxt, v_nxt);
            vga.frame_start <= pix_en && (h_nxt == '0) && (v_nxt == '0);
            vga.pixel_req   <= req_fire;
            if (req_fire) begin
                vga.req_x <= h_la;
                vga.req_y <= v_la;
            end
        end
    end

    assign vga.x      = h_cnt;
    assign vga.y      = v_cnt;
    assign vga.sync_n = 1'b0;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster geometry (same rules, small frame)
// against an edge-count arithmetic reference model.
module tb_vga_timing_gen;
    localparam int CD = 4;
    localparam int HA = 16, HF = 4, HS = 6, HB = 4;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam int FRC = FR * CD;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    vga_timing_gen_if vif ();

    vga_timing_gen #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .vga  (vif.master)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: edges since reset release, last requested pixel.
    longint n = 0;
    int m_rx = 0, m_ry = 0;
    // Latest sampled DUT outputs.
    int s_x, s_y, s_rx, s_ry;
    logic s_bl, s_fs, s_pr, s_vclk, s_hs, s_vs;

    typedef struct {
        logic rst;
        int   x, y;
        logic bl, fs, pr, vclk;
        int   rx, ry;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic act_pos(input int h, input int v);
        return (h < HA) && (v < VA);
    endfunction

    // One clock: advance the model, then sample and compare on the falling edge.
    task automatic step();
        int p, ph, k, nk, px, py, nx, ny;
        logic e_pr, e_fs;
        @(posedge clock);
        if (reset) begin
            n = 0; m_rx = 0; m_ry = 0;
        end else n++;
        p  = int'(n / CD);
        ph = int'(n % CD);
        if (p == 0) begin
            px = HT - 1; py = VT - 1; nk = 0;
        end else begin
            k  = (p - 1) % FR;
            px = k % HT; py = k / HT;
            nk = (k + 1) % FR;
        end
        nx = nk % HT; ny = nk / HT;
        e_pr = (n > 0) && (n == 1 || ph == 0) && act_pos(nx, ny);
        e_fs = (n > 0) && (ph == 0) && (px == 0) && (py == 0);
        if (e_pr) begin m_rx = nx; m_ry = ny; end
        @(negedge clock);
        s_x = int'(vif.x); s_y = int'(vif.y);
        s_rx = int'(vif.req_x); s_ry = int'(vif.req_y);
        s_bl = vif.blank_n; s_fs = vif.frame_start; s_pr = vif.pixel_req;
        s_vclk = vif.vga_clk; s_hs = vif.hsync_n; s_vs = vif.vsync_n;
        chk("model x", vif.x, px);
        chk("model y", vif.y, py);
        chk("model blank_n", vif.blank_n, act_pos(px, py));
        chk("model hsync_n", vif.hsync_n, !(px >= HA + HF && px < HA + HF + HS));
        chk("model vsync_n", vif.vsync_n, !(py >= VA + VF && py < VA + VF + VS));
        chk("model vga_clk", vif.vga_clk, ph >= CD / 2);
        chk("model sync_n", vif.sync_n, 1'b0);
        chk("model frame_start", vif.frame_start, e_fs);
        chk("model pixel_req", vif.pixel_req, e_pr);
        chk("model req_x", vif.req_x, m_rx);
        chk("model req_y", vif.req_y, m_ry);
    endtask

    initial begin
        int c_pr, c_bl, c_hs, c_vs, first_hs;
        logic found;

        //          rst  x       y       bl  fs  pr  vclk rx ry
        tbl[0] = '{1'b1, HT - 1, VT - 1, 0,  0,  0,  0,   0, 0};
        tbl[1] = '{1'b0, HT - 1, VT - 1, 0,  0,  1,  0,   0, 0};
        tbl[2] = '{1'b0, HT - 1, VT - 1, 0,  0,  0,  1,   0, 0};
        tbl[3] = '{1'b0, HT - 1, VT - 1, 0,  0,  0,  1,   0, 0};
        tbl[4] = '{1'b0, 0,      0,      1,  1,  1,  0,   1, 0};
        tbl[5] = '{1'b0, 0,      0,      1,  0,  0,  0,   1, 0};
        tbl[6] = '{1'b0, 0,      0,      1,  0,  0,  1,   1, 0};

        for (int i = 0; i < 7; i++) begin
            reset = tbl[i].rst;
            step();
            chk($sformatf("vec%0d x", i), s_x, tbl[i].x);
            chk($sformatf("vec%0d y", i), s_y, tbl[i].y);
            chk($sformatf("vec%0d blank_n", i), s_bl, tbl[i].bl);
            chk($sformatf("vec%0d frame_start", i), s_fs, tbl[i].fs);
            chk($sformatf("vec%0d pixel_req", i), s_pr, tbl[i].pr);
            chk($sformatf("vec%0d vga_clk", i), s_vclk, tbl[i].vclk);
            chk($sformatf("vec%0d req_x", i), s_rx, tbl[i].rx);
            chk($sformatf("vec%0d req_y", i), s_ry, tbl[i].ry);
        end

        // Whole-frame statistics, window starting at a frame_start sample.
        found = 1'b0;
        for (int i = 0; i < FRC + 100 && !found; i++) begin
            step();
            found = s_fs;
        end
        chk("frame_start seen", found, 1'b1);
        c_pr = int'(s_pr); c_bl = int'(s_bl); c_hs = int'(!s_hs); c_vs = int'(!s_vs);
        first_hs = -1;
        for (int i = 1; i < FRC; i++) begin
            step();
            c_pr += int'(s_pr); c_bl += int'(s_bl);
            c_hs += int'(!s_hs); c_vs += int'(!s_vs);
            if (!s_hs && first_hs < 0) first_hs = i;
            if (s_fs) chk("early frame_start", i, FRC);
        end
        step();
        chk("frame period", s_fs, 1'b1);
        chk("pixel_req per frame", c_pr, HA * VA);
        chk("blank_n high clocks", c_bl, HA * VA * CD);
        chk("hsync_n low clocks", c_hs, HS * CD * VT);
        chk("vsync_n low clocks", c_vs, VS * HT * CD);
        chk("hsync fall offset", first_hs, (HA + HF) * CD);

        // Mid-frame reset for one clock.
        found = 1'b0;
        for (int i = 0; i < FRC + 100 && !found; i++) begin
            step();
            found = (s_x == 10) && (s_y == 6);
        end
        chk("reached (10,6)", found, 1'b1);
        reset = 1'b1;
        step();
        chk("midreset x", s_x, HT - 1);
        chk("midreset y", s_y, VT - 1);
        chk("midreset blank_n", s_bl, 1'b0);
        reset = 1'b0;
        for (int i = 1; i <= CD; i++) begin
            step();
            chk($sformatf("restart frame_start e%0d", i), s_fs, i == CD);
        end

        // Random reset pulses at arbitrary points of the raster.
        for (int it = 0; it < 16; it++) begin
            reset = 1'b0;
            repeat ($urandom_range(1, 900)) step();
            reset = 1'b1;
            repeat ($urandom_range(1, 2)) step();
        end
        reset = 1'b0;
        repeat (200) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
